regfile_mp: RTL and testbench

- Parametrised integer register file for the RISC-V pipeline. Successor to the fixed 32x32, 2-read-port array.
- Configurable data width, register count and read-port count.
- Optional write-to-read bypass from the writeback stage.
- Per-register pending-write scoreboard, so decode can detect RAW hazards locally.
- Registers are cleared by a sequential init sweep after reset, so the array can map to distributed RAM.

---
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised integer register file: NRD combinational read ports, one writeback port,
// optional writeback bypass, per-register pending-write scoreboard, post-reset init sweep.

module regfile_mp_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            run,
  input  logic [AW-1:0]   sel,
  input  logic [XLEN-1:0] arr_data,
  input  logic            arr_busy,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_sel,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] dout,
  output logic            bsy
);
  logic live, hit;

  // x0 and out-of-range indices read as zero and are never busy
  assign live = run && (sel != '0) && ({1'b0, sel} < (AW+1)'(NREG));
  assign hit  = (BYPASS != 0) && wb_valid && (wb_sel == sel);
  assign dout = !live ? '0 : (hit ? wb_data : arr_data);
  assign bsy  = live && arr_busy && !hit;
endmodule

module regfile_mp #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              AW       = 5,
  parameter int              NRD      = 2,
  parameter int              SP_IDX   = 2,
  parameter logic [XLEN-1:0] SP_RESET = 32'h10000,
  parameter int              BYPASS   = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NRD*AW-1:0]   RS_SEL,
  output logic [NRD*XLEN-1:0] RS_DATAOUT,
  output logic [NRD-1:0]      RS_BUSY,
  input  logic                RD_ISSUE_VALID,
  input  logic [AW-1:0]       RD_ISSUE_SEL,
  input  logic                RD_WB_VALID,
  input  logic [AW-1:0]       RD_WB_SEL,
  input  logic [XLEN-1:0]     DATA_IN,
  input  logic                FLUSH,
  output logic                READY
);
  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [AW:0]     cnt;
  logic            ready_q;
  logic [NREG-1:0] busy, busy_nxt;
  logic [XLEN-1:0] regs [NREG];
  logic            wb_ok, we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  assign wb_ok = RD_WB_VALID && (RD_WB_SEL != '0) && ({1'b0, RD_WB_SEL} < (AW+1)'(NREG));

  // Single write port shared by the init sweep and writeback, so the array stays RAM-friendly
  always_comb begin
    we    = 1'b0;
    waddr = RD_WB_SEL;
    wdata = DATA_IN;
    if (state == INIT) begin
      we    = 1'b1;
      waddr = cnt[AW-1:0];
      wdata = (cnt == (AW+1)'(SP_IDX)) ? SP_RESET : '0;
    end else if (wb_ok) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge CLK)
    if (we) regs[waddr] <= wdata;

  // Issue is the newer producer, so it wins over a same-register writeback
  always_comb begin
    busy_nxt = busy;
    if (FLUSH) busy_nxt = '0;
    else
      for (int i = 1; i < NREG; i++) begin
        if (RD_ISSUE_VALID && RD_ISSUE_SEL == AW'(i))  busy_nxt[i] = 1'b1;
        else if (RD_WB_VALID && RD_WB_SEL == AW'(i))   busy_nxt[i] = 1'b0;
      end
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state   <= INIT;
      cnt     <= (AW+1)'(1);
      ready_q <= 1'b0;
      busy    <= '0;
    end else begin
      case (state)
        INIT:
          if (cnt == (AW+1)'(NREG-1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + (AW+1)'(1);
          end
        RUN: busy <= busy_nxt;
        default: state <= INIT;
      endcase
    end

  assign READY = ready_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = RS_SEL[k*AW +: AW];
    regfile_mp_rdport #(.XLEN(XLEN), .AW(AW), .NREG(NREG), .BYPASS(BYPASS)) u_rd (
      .run      (state == RUN),
      .sel      (sel),
      .arr_data (regs[sel]),
      .arr_busy (busy[sel]),
      .wb_valid (RD_WB_VALID),
      .wb_sel   (RD_WB_SEL),
      .wb_data  (DATA_IN),
      .dout     (RS_DATAOUT[k*XLEN +: XLEN]),
      .bsy      (RS_BUSY[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypass instance and a non-bypass instance share stimulus;
// expectations are queued as stimulus is driven and popped when outputs are sampled.

module tb_regfile_mp;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [9:0]  rs_sel;
  logic [63:0] dout, nb_dout;
  logic [1:0]  busy, nb_busy;
  logic        ready, nb_ready;
  logic        iss_v, wb_v, flush;
  logic [4:0]  iss_sel, wb_sel;
  logic [31:0] din;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  regfile_mp #(.BYPASS(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .RS_SEL(rs_sel), .RS_DATAOUT(dout), .RS_BUSY(busy),
    .RD_ISSUE_VALID(iss_v), .RD_ISSUE_SEL(iss_sel), .RD_WB_VALID(wb_v), .RD_WB_SEL(wb_sel),
    .DATA_IN(din), .FLUSH(flush), .READY(ready)
  );

  regfile_mp #(.BYPASS(0)) nb (
    .CLK(CLK), .RST_N(RST_N), .RS_SEL(rs_sel), .RS_DATAOUT(nb_dout), .RS_BUSY(nb_busy),
    .RD_ISSUE_VALID(iss_v), .RD_ISSUE_SEL(iss_sel), .RD_WB_VALID(wb_v), .RD_WB_SEL(wb_sel),
    .DATA_IN(din), .FLUSH(flush), .READY(nb_ready)
  );

  localparam int RDY = 0, D0 = 1, D1 = 2, B0 = 3, B1 = 4, ND0 = 5, NB0 = 6, NRDY = 7;

  function automatic logic [31:0] obs(int src);
    case (src)
      RDY:  return {31'b0, ready};
      D0:   return dout[31:0];
      D1:   return dout[63:32];
      B0:   return {31'b0, busy[0]};
      B1:   return {31'b0, busy[1]};
      ND0:  return nb_dout[31:0];
      NB0:  return {31'b0, nb_busy[0]};
      default: return {31'b0, nb_ready};
    endcase
  endfunction

  task automatic push(string tag, int src, logic [31:0] e);
    exp_t x;
    x.tag = tag; x.src = src; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic chk();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.src);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic rd(logic [4:0] a, logic [4:0] b);
    rs_sel = {b, a};
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    iss_v = 1'b0; wb_v = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    idle(); iss_sel = '0; wb_sel = '0; din = '0; rd(2, 1);
    #1 RST_N = 1'b0;
    #2;
    push("rst_ready", RDY, 0); push("rst_busy0", B0, 0); push("rst_busy1", B1, 0);
    push("rst_dout0", D0, 0);
    chk();
    @(posedge CLK); #1 RST_N = 1'b1;

    // Init sweep: READY rises on the 31st edge after release
    for (int i = 1; i <= 31; i++) begin
      tick();
      push("sweep_ready", RDY, (i == 31) ? 32'd1 : 32'd0);
      push("sweep_nb_ready", NRDY, (i == 31) ? 32'd1 : 32'd0);
      if (i == 30) push("sweep_dout_gated", D0, 0);
      chk();
    end

    rd(2, 1); #1;
    push("init_x2", D0, 32'h0001_0000); push("init_x1", D1, 0); push("init_nb_x2", ND0, 32'h0001_0000);
    chk();
    rd(31, 0); #1;
    push("init_x31", D0, 0); push("init_x0", D1, 0);
    chk();

    // Write x5 with same-cycle read: bypass vs no bypass
    tick();
    wb_v = 1'b1; wb_sel = 5'd5; din = 32'hDEAD_BEEF; rd(5, 5); #2;
    push("byp_same", D0, 32'hDEAD_BEEF); push("nobyp_same", ND0, 0);
    chk();
    tick(); idle(); #2;
    push("byp_next", D0, 32'hDEAD_BEEF); push("byp_next_p1", D1, 32'hDEAD_BEEF);
    push("nobyp_next", ND0, 32'hDEAD_BEEF);
    chk();

    // x0 writes are dropped
    wb_v = 1'b1; wb_sel = 5'd0; din = 32'hFFFF_FFFF; rd(0, 0); #2;
    push("x0_same_p0", D0, 0); push("x0_same_p1", D1, 0);
    chk();
    tick(); idle(); #2;
    push("x0_p0", D0, 0); push("x0_p1", D1, 0); push("x0_busy0", B0, 0); push("x0_busy1", B1, 0);
    chk();

    // Scoreboard: issue x7, then writeback x7
    iss_v = 1'b1; iss_sel = 5'd7; rd(7, 7); #2;
    push("x7_pre_issue", B0, 0);
    chk();
    tick(); idle(); #2;
    push("x7_busy_p0", B0, 1); push("x7_busy_p1", B1, 1); push("x7_nb_busy", NB0, 1);
    chk();
    wb_v = 1'b1; wb_sel = 5'd7; din = 32'h77; #1;
    push("x7_wb_byp_busy", B0, 0); push("x7_wb_byp_data", D0, 32'h77);
    push("x7_wb_nb_busy", NB0, 1); push("x7_wb_nb_data", ND0, 0);
    chk();
    tick(); idle(); #2;
    push("x7_after_wb", B0, 0); push("x7_nb_after_wb", NB0, 0); push("x7_data", D0, 32'h77);
    chk();

    // Issue and writeback x7 together: stays busy
    iss_v = 1'b1; iss_sel = 5'd7; wb_v = 1'b1; wb_sel = 5'd7; din = 32'h88;
    tick(); idle(); #2;
    push("x7_iss_wb_busy", B0, 1); push("x7_iss_wb_data", D0, 32'h88);
    chk();

    // Issue x3 with writeback x7 (different regs), then issue x9
    iss_v = 1'b1; iss_sel = 5'd3; wb_v = 1'b1; wb_sel = 5'd7; din = 32'h99;
    tick(); idle();
    iss_v = 1'b1; iss_sel = 5'd9;
    tick(); idle();
    rd(3, 9); #1;
    push("x3_busy", B0, 1); push("x9_busy", B1, 1);
    chk();
    rd(7, 9); #1;
    push("x7_cleared", B0, 0); push("x7_data99", D0, 32'h99);
    chk();

    // Flush beats a simultaneous issue
    flush = 1'b1; iss_v = 1'b1; iss_sel = 5'd4; rd(3, 4);
    tick(); idle(); #1;
    push("flush_x3", B0, 0); push("flush_x4", B1, 0);
    chk();
    rd(9, 7); #1;
    push("flush_x9", B0, 0); push("flush_x7", B1, 0);
    chk();

    // Reset in RUN with busy bits set and x1 written
    iss_v = 1'b1; iss_sel = 5'd3; wb_v = 1'b1; wb_sel = 5'd1; din = 32'h1234;
    tick(); idle(); rd(3, 1); #1;
    push("run_x3_busy", B0, 1); push("run_x1", D1, 32'h1234); push("run_ready", RDY, 1);
    chk();
    #1 RST_N = 1'b0; #1;
    push("runrst_ready", RDY, 0); push("runrst_busy", B0, 0); push("runrst_dout", D1, 0);
    chk();
    #2 RST_N = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      push("resweep_ready", RDY, 0);
      chk();
    end

    // Counter is at 10: pulse reset mid-sweep
    #1 RST_N = 1'b0; #1;
    push("midrst_ready", RDY, 0); push("midrst_busy0", B0, 0); push("midrst_busy1", B1, 0);
    chk();
    #2 RST_N = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      push("resweep2_ready", RDY, (i == 31) ? 32'd1 : 32'd0);
      chk();
    end
    rd(1, 2); #1;
    push("resweep_x1", D0, 0); push("resweep_x2", D1, 32'h0001_0000);
    chk();
    rd(3, 0); #1;
    push("resweep_x3_busy", B0, 0);
    chk();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
